// File: rtl/saida_console_pkg.sv
// Shared types for the console UART (FSM states, data width).
// PARIDADE exists only when SAIDA_CONSOLE_PARIDADE_EN is defined.
package saida_console_pkg;

  localparam int BITS_DADO = 8;

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
`ifdef SAIDA_CONSOLE_PARIDADE_EN
    PARIDADE,
`endif
    PARADA
  } estado_e;

endpackage

// File: rtl/fifo_stdout.sv
// Single-clock byte FIFO with combinational head read.
// Build option SAIDA_CONSOLE_PARIDADE_EN does not affect this file.
module fifo_stdout
  import saida_console_pkg::*;
#(
  parameter  int PROF_FIFO = 16,
  localparam int LARG_PTR  = $clog2(PROF_FIFO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [BITS_DADO-1:0] din,
  output logic [BITS_DADO-1:0] dout,
  output logic                 vazio,
  output logic                 cheio,
  output logic [LARG_PTR:0]    nivel
);

  logic [BITS_DADO-1:0] mem_q [PROF_FIFO];
  logic [LARG_PTR-1:0]  wr_q;
  logic [LARG_PTR-1:0]  rd_q;
  logic [LARG_PTR:0]    nivel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      nivel_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   nivel_q <= nivel_q + 1'b1;
        2'b01:   nivel_q <= nivel_q - 1'b1;
        default: nivel_q <= nivel_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign nivel = nivel_q;
  assign vazio = (nivel_q == '0);
  assign cheio = (nivel_q == (LARG_PTR+1)'(PROF_FIFO));

endmodule

// File: rtl/saida_console_uart.sv
// Console sink: buffers stdout bytes and sends 8N1 UART frames.
// Define SAIDA_CONSOLE_PARIDADE_EN for an even-parity bit (8E1).
module saida_console_uart
  import saida_console_pkg::*;
#(
  parameter  int DIV_BAUD  = 434,
  parameter  int PROF_FIFO = 16,
  localparam int LARG_PTR  = $clog2(PROF_FIFO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stdout_we,
  input  logic [31:0]       stdout,
  output logic              tx,
  output logic              vazio,
  output logic              cheio,
  output logic              ocupado,
  output logic              overflow,
  output logic [LARG_PTR:0] nivel
);

  localparam int LARG_CNT = $clog2(DIV_BAUD);
  localparam int LARG_IDX = $clog2(BITS_DADO);
  localparam logic [LARG_CNT-1:0] CNT_FIM = LARG_CNT'(DIV_BAUD - 1);
  localparam logic [LARG_IDX-1:0] IDX_FIM = LARG_IDX'(BITS_DADO - 1);

  estado_e              est_q, est_d;
  logic [LARG_CNT-1:0]  cnt_q, cnt_d;
  logic [LARG_IDX-1:0]  idx_q, idx_d;
  logic [BITS_DADO-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q, ovf_d;
  logic                 push, pop, fim_bit;
  logic [BITS_DADO-1:0] cabeca;
  logic                 unused_alto;
`ifdef SAIDA_CONSOLE_PARIDADE_EN
  logic                 par_q, par_d;
`endif

  assign unused_alto = ^stdout[31:BITS_DADO];

  // A push is still accepted at full when the FSM pops the same cycle.
  assign push  = stdout_we & (~cheio | pop);
  assign ovf_d = ovf_q | (stdout_we & ~push);

  fifo_stdout #(.PROF_FIFO(PROF_FIFO)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (stdout[BITS_DADO-1:0]),
    .dout (cabeca),
    .vazio(vazio),
    .cheio(cheio),
    .nivel(nivel)
  );

  assign fim_bit = (cnt_q == CNT_FIM);

  always_comb begin
    est_d = est_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sh_d  = sh_q;
    pop   = 1'b0;
`ifdef SAIDA_CONSOLE_PARIDADE_EN
    par_d = par_q;
`endif
    if (est_q != OCIOSO) cnt_d = fim_bit ? '0 : cnt_q + 1'b1;
    case (est_q)
      OCIOSO: begin
        if (!vazio) begin
          pop   = 1'b1;
          sh_d  = cabeca;
          cnt_d = '0;
          est_d = INICIO;
`ifdef SAIDA_CONSOLE_PARIDADE_EN
          par_d = ^cabeca;
`endif
        end
      end
      INICIO: begin
        if (fim_bit) begin
          idx_d = '0;
          est_d = DADOS;
        end
      end
      DADOS: begin
        if (fim_bit) begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 1'b1;
`ifdef SAIDA_CONSOLE_PARIDADE_EN
          if (idx_q == IDX_FIM) est_d = PARIDADE;
`else
          if (idx_q == IDX_FIM) est_d = PARADA;
`endif
        end
      end
`ifdef SAIDA_CONSOLE_PARIDADE_EN
      PARIDADE: begin
        if (fim_bit) est_d = PARADA;
      end
`endif
      PARADA: begin
        if (fim_bit) begin
          if (!vazio) begin
            pop   = 1'b1;
            sh_d  = cabeca;
            est_d = INICIO;
`ifdef SAIDA_CONSOLE_PARIDADE_EN
            par_d = ^cabeca;
`endif
          end else begin
            est_d = OCIOSO;
          end
        end
      end
      default: est_d = OCIOSO;
    endcase
  end

  // tx is registered from next-state values so the pin is glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (est_d)
      INICIO:   tx_d = 1'b0;
      DADOS:    tx_d = sh_d[0];
`ifdef SAIDA_CONSOLE_PARIDADE_EN
      PARIDADE: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      est_q <= OCIOSO;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q  <= '0;
      tx_q  <= 1'b1;
      ovf_q <= 1'b0;
`ifdef SAIDA_CONSOLE_PARIDADE_EN
      par_q <= 1'b0;
`endif
    end else begin
      est_q <= est_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      tx_q  <= tx_d;
      ovf_q <= ovf_d;
`ifdef SAIDA_CONSOLE_PARIDADE_EN
      par_q <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign overflow = ovf_q;
  assign ocupado  = (est_q != OCIOSO) | ~vazio;

endmodule

// File: tb/tb_saida_console_uart.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor checks tx.
// Honours SAIDA_CONSOLE_PARIDADE_EN for frame length and parity bit.
module tb_saida_console_uart;

  localparam int DIV  = 4;
  localparam int PROF = 4;
`ifdef SAIDA_CONSOLE_PARIDADE_EN
  localparam int NBITS = 11;
  localparam logic [NBITS-1:0] F41 = 11'b10010000010;
  localparam logic [NBITS-1:0] F07 = 11'b11000001110;
`else
  localparam int NBITS = 10;
  localparam logic [NBITS-1:0] F41 = 10'b1010000010;
  localparam logic [NBITS-1:0] F07 = 10'b1000001110;
`endif
  localparam int FRAME = NBITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stdout_we = 1'b0;
  logic [31:0] stdout = '0;
  logic        tx, vazio, cheio, ocupado, overflow;
  logic [2:0]  nivel;

  saida_console_uart #(.DIV_BAUD(DIV), .PROF_FIFO(PROF)) dut (
    .clk      (clk),
    .rst      (rst),
    .stdout_we(stdout_we),
    .stdout   (stdout),
    .tx       (tx),
    .vazio    (vazio),
    .cheio    (cheio),
    .ocupado  (ocupado),
    .overflow (overflow),
    .nivel    (nivel)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_frames = 0;
  int mon_ph = -1;
  int niv_max = 0;
  int start_cyc[$];
  logic [7:0] exp_q[$];
  logic [NBITS-1:0] mon_exp, mon_got, mon_last;

  always @(posedge clk) cyc++;

  task automatic chk(string nome, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nome, act, req, $time);
    end
  endtask

  function automatic logic [NBITS-1:0] mk_frame(logic [7:0] d);
    logic [NBITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef SAIDA_CONSOLE_PARIDADE_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Monitor: every cycle of a frame is compared with the expected bit.
  always @(negedge clk) begin
    if (rst) begin
      mon_ph = -1;
    end else begin
      if (int'(nivel) > niv_max) niv_max = int'(nivel);
      if (mon_ph < 0 && tx === 1'b0) begin
        n_frames++;
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL frame_unexpected: got start bit required idle (t=%0t)", $time);
          mon_exp = '1;
          mon_exp[0] = 1'b0;
        end else begin
          mon_exp = mk_frame(exp_q.pop_front());
        end
        mon_ph = 0;
      end
      if (mon_ph >= 0) begin
        chk("tx_bit", 32'(tx), 32'(mon_exp[mon_ph/DIV]));
        if (mon_ph % DIV == DIV/2) mon_got[mon_ph/DIV] = tx;
        if (mon_ph == FRAME - 1) begin
          mon_last = mon_got;
          mon_ph   = -1;
        end else begin
          mon_ph++;
        end
      end
    end
  end

  task automatic wr(logic [31:0] v);
    stdout_we = 1'b1;
    stdout    = v;
    @(posedge clk);
    #1;
    stdout_we = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (ocupado && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain(string nome);
    int n = 0;
    while ((exp_q.size() != 0 || mon_ph >= 0 || ocupado) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nome, "_drain_ok"}, 32'(n < 3000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fr0, ns;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_vazio", 32'(vazio), 1);
    chk("rst_cheio", 32'(cheio), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_nivel", 32'(nivel), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_tx", 32'(tx), 1);

    exp_q.push_back(8'h41);
    wr(32'h0000_0041);
    busy_len(n);
    chk("single_len", n, FRAME + 1);
    chk("single_bits", 32'(mon_last), 32'(F41));

    niv_max = 0;
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    wr(32'h48);
    wr(32'h69);
    busy_len(n);
    chk("b2b_len", n, 2 * FRAME);
    ns = start_cyc.size();
    chk("b2b_gap", start_cyc[ns-1] - start_cyc[ns-2], FRAME);
    chk("b2b_peak", niv_max, 1);

    exp_q.push_back(8'h55);
    wr(32'hDEAD_BE55);
    drain("upper");
    chk("upper_bits", 32'(mon_last[8:1]), 32'h55);

    exp_q.push_back(8'h07);
    wr(32'h07);
    busy_len(n);
    chk("b07_len", n, FRAME + 1);
    chk("b07_bits", 32'(mon_last), 32'(F07));

    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h30 + i));
    exp_q.push_back(8'h3A);
    for (int i = 0; i < 5; i++) wr(32'h30 + i);
    repeat (FRAME - 4) @(posedge clk);
    #1;
    chk("pp_pre_cheio", 32'(cheio), 1);
    chk("pp_pre_nivel", 32'(nivel), PROF);
    wr(32'h3A);
    chk("pp_nivel", 32'(nivel), PROF);
    chk("pp_cheio", 32'(cheio), 1);
    chk("pp_overflow", 32'(overflow), 0);
    drain("pp");

    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h30 + i));
    for (int i = 0; i < 6; i++) wr(32'h30 + i);
    chk("ovf_cheio", 32'(cheio), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_nivel", 32'(nivel), PROF);
    drain("ovf");
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_vazio", 32'(vazio), 1);

    exp_q.push_back(8'h61);
    for (int i = 0; i < 4; i++) wr(32'h61 + i);
    chk("mid_nivel", 32'(nivel), 3);
    repeat (14) @(posedge clk);
    #1;
    chk("mid_in_bit3", mon_ph / DIV, 4);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_tx", 32'(tx), 1);
    chk("mid_vazio", 32'(vazio), 1);
    chk("mid_nivel0", 32'(nivel), 0);
    chk("mid_ocupado", 32'(ocupado), 0);
    chk("mid_ovf_clr", 32'(overflow), 0);
    fr0 = n_frames;
    repeat (3 * FRAME) @(posedge clk);
    #1;
    chk("mid_no_frames", n_frames, fr0);
    chk("mid_tx_idle", 32'(tx), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/saida_console_uart.md
Name: saida_console_uart

Overview:
- Downstream consumer of the processor's console output.
- Captures every store the processor makes to the stdout word, buffers the low byte in a FIFO, and serialises it as 8N1 UART frames on one TX pin.
- The processor never stalls: bytes written while the buffer is full are dropped and flagged.
- Sits between the processor top and the board pin.

Parameters:
DIV_BAUD, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
PROF_FIFO, 16, FIFO depth in bytes; power of two, 2..256
LARG_PTR, $clog2(PROF_FIFO), FIFO pointer width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
stdout_we  input  1  one-cycle strobe: processor store to stdout address this cycle
stdout  input  32  stdout word written; only bits [7:0] are transmitted
tx  output  1  UART serial line, idle high
vazio  output  1  FIFO empty
cheio  output  1  FIFO full
ocupado  output  1  FIFO non-empty or frame in progress
overflow  output  1  sticky: at least one byte dropped since reset
nivel  output  LARG_PTR+1  current FIFO occupancy, 0..PROF_FIFO

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - rst is synchronous and active-high; all state changes on the rising edge of clk.
- Reset values:
  - Outputs: tx=1, vazio=1, cheio=0, ocupado=0, overflow=0, nivel=0.
  - Internal: FSM=OCIOSO, pointers=0, baud counter=0, bit index=0.
- Reset mid-frame: tx returns to 1 after the reset edge, the frame is abandoned and the FIFO is flushed.
- FIFO:
  - Push when stdout_we=1 and (not cheio, or a pop occurs in the same cycle).
  - stdout_we=1 while cheio=1 with no simultaneous pop: byte discarded, overflow<=1, nivel unchanged.
  - Simultaneous push and pop: nivel unchanged, both take effect.
  - Pointers wrap modulo PROF_FIFO.
  - cheio = (nivel==PROF_FIFO); vazio = (nivel==0).
- FSM states: OCIOSO, INICIO, DADOS, PARADA.
  - OCIOSO:
    - tx=1.
    - If not vazio: pop the head byte into an 8-bit shift register, go to INICIO, clear the baud counter.
  - INICIO:
    - tx=0 for DIV_BAUD cycles, then DADOS with bit index=0.
  - DADOS:
    - tx=shift[0], LSB first.
    - Every DIV_BAUD cycles: shift right and increment the index; after index 7 completes, go to PARADA.
  - PARADA:
    - tx=1 for DIV_BAUD cycles.
    - Then: if not vazio, pop and go straight to INICIO (no extra idle bit); else go to OCIOSO.
- Latency:
  - Push at edge N into an empty FIFO with FSM in OCIOSO: pop at edge N+1, tx low from edge N+1.
  - Frame length is exactly 10*DIV_BAUD cycles.
- Baud counter:
  - Counts 0..DIV_BAUD-1; wraps on the bit boundary.
  - Width is the minimum holding DIV_BAUD-1.
- ocupado = (state!=OCIOSO) | ~vazio; it is registered-consistent with the FSM and FIFO state.
- Upper 24 bits of stdout are ignored.

Optional Feature:
- Macro: SAIDA_CONSOLE_PARIDADE_EN.
- Defined:
  - An even-parity bit is inserted between data bit 7 and the stop bit.
  - New state PARIDADE, DIV_BAUD cycles, tx = XOR of the 8 data bits.
  - Frame = 11*DIV_BAUD cycles.
- Undefined: 8N1 exactly as above; no PARIDADE state exists.

Decomposition:
- Package saida_console_pkg: the FSM state enum (OCIOSO, INICIO, DADOS, PARIDADE, PARADA) and the constant BITS_DADO=8.
- Sub-module fifo_stdout, a synchronous single-clock FIFO with:
  - inputs clk, rst, push, pop, din[7:0];
  - outputs dout[7:0] (head, combinational read), vazio, cheio, nivel.
- The overflow flag and the UART FSM stay in saida_console_uart.

Test Plan:
- Reset and single byte:
  - Stimulus: DIV_BAUD=4; after reset hold tx=1; stdout_we=1 with stdout=32'h0000_0041 for one cycle.
  - Required: tx sequence 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles; ocupado falls the cycle after stop.
- Back-to-back:
  - Stimulus: write 'H' (0x48) and 'i' (0x69) on consecutive cycles.
  - Required: two frames with no idle gap, 80 cycles total at DIV_BAUD=4; nivel peaks at 1.
- Upper bits ignored: stdout=32'hDEAD_BE55 -> data bits on tx = 0x55 LSB first.
- Overflow:
  - Stimulus: PROF_FIFO=4, DIV_BAUD=100; write 6 bytes 0x30..0x35 on consecutive cycles.
  - Required: cheio=1 and overflow=1; bytes 0x30..0x34 transmitted (first popped immediately), 0x35 dropped; overflow stays 1 until rst.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full, push on the exact cycle PARADA pops.
  - Required: push accepted, nivel stays PROF_FIFO, overflow unchanged.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle during DADOS bit 3 with 3 bytes queued.
  - Required: tx=1, vazio=1, nivel=0 after the edge; no further frames.
- Parity build (SAIDA_CONSOLE_PARIDADE_EN): byte 0x07 -> parity bit 1, frame 44 cycles at DIV_BAUD=4.
